count_seg_display: RTL and testbench



---
 rtl/count_seg_display_pkg.sv | 27 ++
 rtl/count_seg_display_if.sv | 17 +
 rtl/count_seg_display_hex_to_seg.sv | 32 +++
 rtl/count_seg_display.sv | 88 ++++++++
 tb/tb_count_seg_display.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/count_seg_display_pkg.sv
// Shared constants and types for the counter seven-segment display block.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/count_seg_display_if.sv
// Counter inputs and display outputs of the seven-segment display block.
interface count_seg_display_if;
  logic       a0;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       hold;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [7:0] wrap_cnt;

  modport master (output a0, a1, a2, a3, hold,
                  input  seg, dp, an, wrap_cnt);
  modport slave  (input  a0, a1, a2, a3, hold,
                  output seg, dp, an, wrap_cnt);
endinterface

// File: rtl/count_seg_display_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_seg_display.sv
// Multiplexed 4-digit display of live count, F->0 rollover count and a held count.
// All state is synchronous to clk with synchronous active-high rst.
module count_seg_display
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  count_seg_display_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [3:0]    cnt_in;
  logic [3:0]    cnt_q;
  logic [7:0]    wrap_q;
  logic [3:0]    held_q;
  logic          held_valid;
  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          wrap;
  logic          tick;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    an_q;

  assign cnt_in = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign wrap   = (cnt_q == 4'hF) && (cnt_in == 4'h0);
  assign tick   = (presc == PRESC_MAX);

  always_comb begin
    nibble = cnt_q;
    case (idx)
      2'd0: nibble = cnt_q;
      2'd1: nibble = wrap_q[3:0];
      2'd2: nibble = wrap_q[7:4];
      2'd3: nibble = held_q;
      default: nibble = cnt_q;
    endcase
  end

  hex_to_seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Output registers sample the pre-edge idx/nibble, so the display lags the scan by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'h0;
      wrap_q     <= 8'h00;
      held_q     <= 4'h0;
      held_valid <= 1'b0;
      presc      <= '0;
      idx        <= 2'd0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_HEX_0;
      dp_q       <= 1'b1;
    end else begin
      cnt_q <= cnt_in;
      if (wrap)
        wrap_q <= wrap_q + 8'd1;
      if (bus.hold) begin
        held_q     <= cnt_q;
        held_valid <= 1'b1;
      end
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_dec;
      dp_q  <= !((idx == 2'd3) && held_valid);
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.an       = an_q;
  assign bus.wrap_cnt = wrap_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Randomized and directed self-checking bench for count_seg_display with a behavioural model.
module tb_count_seg_display;

  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  count_seg_display_if bus();

  count_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan position comes from cycles elapsed since reset, not a prescaler.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m_cnt;
  int         m_wraps;
  int         m_held;
  bit         m_hvalid;
  int         m_slot;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic modelStep(input int din, input bit h, input bit r);
    int digit;
    int nib;
    if (r) begin
      m_cnt = 0; m_wraps = 0; m_held = 0; m_hvalid = 0; m_slot = 0;
      exp_an = 4'b1110; exp_seg = 7'h40; exp_dp = 1'b1;
    end else begin
      digit = (m_slot / DIV) % 4;
      case (digit)
        0: nib = m_cnt;
        1: nib = m_wraps % 16;
        2: nib = m_wraps / 16;
        default: nib = m_held;
      endcase
      exp_an  = 4'(15 - (1 << digit));
      exp_seg = glyph[nib];
      exp_dp  = !(digit == 3 && m_hvalid);
      if (m_cnt == 15 && din == 0) m_wraps = (m_wraps + 1) % 256;
      if (h) begin m_held = m_cnt; m_hvalid = 1; end
      m_cnt = din;
      m_slot++;
    end
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp ||
        bus.wrap_cnt !== 8'(m_wraps)) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got an=%b seg=%h dp=%b wrap=%h, expected an=%b seg=%h dp=%b wrap=%h",
               name, $time, bus.an, bus.seg, bus.dp, bus.wrap_cnt,
               exp_an, exp_seg, exp_dp, 8'(m_wraps));
    end
  endtask

  task automatic checkLiteral(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge and compare just after it.
  task automatic applyStimulus(input int din, input bit h, input bit r, input string name);
    logic [3:0] d;
    d = 4'(din);
    {bus.a3, bus.a2, bus.a1, bus.a0} = d;
    bus.hold = h;
    rst = r;
    @(posedge clk);
    modelStep(din, h, r);
    #1;
    checkOutput(name);
  endtask

  logic [3:0] an_seq [9] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110,
                             4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1011};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.hold = 1'b0;
    {bus.a3, bus.a2, bus.a1, bus.a0} = 4'h9;

    // Reset behaviour
    applyStimulus(9, 0, 1, "reset1");
    applyStimulus(9, 0, 1, "reset2");
    checkLiteral("reset_an", {4'h0, bus.an}, 8'h0E);
    checkLiteral("reset_seg", {1'b0, bus.seg}, 8'h40);
    applyStimulus(9, 0, 0, "post_reset");
    checkLiteral("post_reset_an", {4'h0, bus.an}, 8'h0E);
    checkLiteral("post_reset_seg", {1'b0, bus.seg}, 8'h40);
    checkLiteral("post_reset_wrap", bus.wrap_cnt, 8'h00);

    // Fixed input scan order
    applyStimulus(3, 0, 1, "scan_reset");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(3, 0, 0, "scan");
      checkLiteral("scan_an", {4'h0, bus.an}, {4'h0, an_seq[i]});
      if (i == 2) checkLiteral("scan_seg_d0", {1'b0, bus.seg}, 8'h30);
      if (i == 5) checkLiteral("scan_seg_d1", {1'b0, bus.seg}, 8'h40);
    end

    // Seventeen full count sweeps
    for (int k = 0; k < 17; k++)
      for (int v = 0; v < 16; v++) applyStimulus(v, 0, 0, "sweep");
    applyStimulus(0, 0, 0, "sweep_end");
    checkLiteral("wrap_17", bus.wrap_cnt, 8'h11);
    applyStimulus(15, 0, 0, "f_to_1a");
    applyStimulus(1, 0, 0, "f_to_1b");
    applyStimulus(14, 0, 0, "e_to_0a");
    applyStimulus(0, 0, 0, "e_to_0b");
    checkLiteral("no_false_wrap", bus.wrap_cnt, 8'h11);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, "wrap_digits");
      if (bus.an == 4'b1101) checkLiteral("digit1_glyph", {1'b0, bus.seg}, 8'h79);
      if (bus.an == 4'b1011) checkLiteral("digit2_glyph", {1'b0, bus.seg}, 8'h79);
    end

    // 256 rollovers return the counter to zero
    applyStimulus(0, 0, 1, "wrap256_reset");
    for (int k = 0; k < 256; k++) begin
      applyStimulus(15, 0, 0, "wrap256");
      applyStimulus(0, 0, 0, "wrap256");
    end
    checkLiteral("wrap_256", bus.wrap_cnt, 8'h00);

    // Hold capture
    applyStimulus(0, 0, 1, "hold_reset");
    applyStimulus(10, 0, 0, "hold_setup");
    applyStimulus(10, 1, 0, "hold_pulse");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2, 0, 0, "hold_scan");
      if (bus.an == 4'b0111) begin
        checkLiteral("held_glyph", {1'b0, bus.seg}, 8'h08);
        checkLiteral("held_dp", {7'h0, bus.dp}, 8'h00);
      end
      if (bus.an == 4'b1110 && i > 2) checkLiteral("live_glyph", {1'b0, bus.seg}, 8'h24);
    end
    applyStimulus(5, 1, 1, "hold_with_reset");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5, 0, 0, "hold_rst_scan");
      if (bus.an == 4'b0111) checkLiteral("hold_rst_dp", {7'h0, bus.dp}, 8'h01);
    end

    // Reset mid-scan at digit 2
    applyStimulus(0, 0, 1, "mid_reset0");
    for (int i = 0; i < 9; i++) applyStimulus(7, 0, 0, "mid_run");
    applyStimulus(7, 0, 1, "mid_reset");
    checkLiteral("mid_reset_an", {4'h0, bus.an}, 8'h0E);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(7, 0, 0, "mid_restart");
      checkLiteral("mid_restart_an", {4'h0, bus.an}, (i < 4) ? 8'h0E : 8'h0D);
    end

    // Random traffic: fully random inputs, then mostly-incrementing counts to provoke wraps
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 63) == 0), "rand");
    begin
      int v;
      v = 0;
      for (int i = 0; i < 1500; i++) begin
        v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : (v + 1) % 16;
        applyStimulus(v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0), "rand_inc");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
